// File: rtl/cache_pkg.sv
// Shared cache-side definitions: bus widths, L1 address split and write-buffer types.
package cache_pkg;

   localparam int DATA_WIDTH          = 32;
   localparam int MM_BLOCK_COUNT_BITS = 10;
   localparam int ADDR_WIDTH          = MM_BLOCK_COUNT_BITS;
   localparam int L1_INDEX_BITS       = 4;
   localparam int L1_TAG_BITS         = ADDR_WIDTH - L1_INDEX_BITS;

   typedef enum logic [0:0] {
      DRAIN_IDLE,
      DRAIN_REQ
   } wb_drain_state_t;

   typedef struct packed {
      logic                  valid;
      logic [ADDR_WIDTH-1:0] addr;
      logic [DATA_WIDTH-1:0] data;
   } wb_entry_t;

endpackage

// File: rtl/write_buffer_if.sv
// Store, lookup and memory-drain signals of the write buffer.
// The buffer uses the slave modport; the controller/memory side uses master.
interface write_buffer_if;
   import cache_pkg::*;

   logic                  wr_valid;
   logic                  wr_ready;
   logic [ADDR_WIDTH-1:0] wr_addr;
   logic [DATA_WIDTH-1:0] wr_data;

   logic [ADDR_WIDTH-1:0] lk_addr;
   logic                  lk_hit;
   logic [DATA_WIDTH-1:0] lk_data;

   logic                  mem_req;
   logic                  mem_ack;
   logic [ADDR_WIDTH-1:0] mem_addr;
   logic [DATA_WIDTH-1:0] mem_data;

   modport slave (
      input  wr_valid, wr_addr, wr_data, lk_addr, mem_ack,
      output wr_ready, lk_hit, lk_data, mem_req, mem_addr, mem_data
   );

   modport master (
      output wr_valid, wr_addr, wr_data, lk_addr, mem_ack,
      input  wr_ready, lk_hit, lk_data, mem_req, mem_addr, mem_data
   );

endinterface

// File: rtl/write_buffer_match.sv
// wb_match: combinational CAM search over the buffer entries, walking from
// head (oldest) to youngest so the last match found is the youngest one.
module wb_match
   import cache_pkg::*;
#(
   parameter  int DEPTH    = 4,
   localparam int PTR_BITS = $clog2(DEPTH)
) (
   input  wb_entry_t             entries [DEPTH],
   input  logic [PTR_BITS-1:0]   head,
   input  logic                  exclude_head,
   input  logic [ADDR_WIDTH-1:0] key,
   output logic                  hit,
   output logic [PTR_BITS-1:0]   idx,
   output logic [DATA_WIDTH-1:0] data
);

   logic [PTR_BITS-1:0] pos;

   always_comb begin
      hit  = 1'b0;
      idx  = '0;
      data = '0;
      pos  = '0;
      for (int k = 0; k < DEPTH; k++) begin
         pos = head + PTR_BITS'(k);
         if (entries[pos].valid && (entries[pos].addr == key) &&
             !(exclude_head && (k == 0))) begin
            hit  = 1'b1;
            idx  = pos;
            data = entries[pos].data;
         end
      end
   end

endmodule

// File: rtl/write_buffer.sv
// Write-through store buffer: circular FIFO drained to memory by req/ack,
// with read-after-write lookup. Define WB_COALESCE_EN to merge stores to a buffered address.
module write_buffer
   import cache_pkg::*;
#(
   parameter  int DEPTH    = 4,
   localparam int PTR_BITS = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              reset,
   write_buffer_if.slave     bus,
   output logic              empty,
   output logic [PTR_BITS:0] count
);

   wb_entry_t             entries_q [DEPTH];
   wb_entry_t             entries_d [DEPTH];
   logic [PTR_BITS-1:0]   head_q, head_d;
   logic [PTR_BITS-1:0]   tail_q, tail_d;
   logic [PTR_BITS:0]     count_q, count_d;
   wb_drain_state_t       state_q, state_d;
   logic                  mem_req_q, mem_req_d;
   logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
   logic [DATA_WIDTH-1:0] mem_data_q, mem_data_d;

   logic                  full;
   logic                  push;
   logic                  alloc;
   logic                  coal_wr;
   logic                  pop;
   logic                  coal_hit;
   logic [PTR_BITS-1:0]   coal_idx;

   assign full = (count_q == (PTR_BITS+1)'(DEPTH));

   wb_match #(.DEPTH(DEPTH)) u_lookup (
      .entries      (entries_q),
      .head         (head_q),
      .exclude_head (1'b0),
      .key          (bus.lk_addr),
      .hit          (bus.lk_hit),
      .idx          (),
      .data         (bus.lk_data)
   );

`ifdef WB_COALESCE_EN
   logic [DATA_WIDTH-1:0] coal_old_data;

   // The head being presented to memory must not change under the request.
   wb_match #(.DEPTH(DEPTH)) u_coalesce (
      .entries      (entries_q),
      .head         (head_q),
      .exclude_head (state_q == DRAIN_REQ),
      .key          (bus.wr_addr),
      .hit          (coal_hit),
      .idx          (coal_idx),
      .data         (coal_old_data)
   );
`else
   assign coal_hit = 1'b0;
   assign coal_idx = '0;
`endif

   assign bus.wr_ready = !full || coal_hit;
   assign push         = bus.wr_valid && bus.wr_ready;
   assign alloc        = push && !coal_hit;
   assign coal_wr      = push && coal_hit;
   assign pop          = (state_q == DRAIN_REQ) && bus.mem_ack;

   // Entry storage, pointers and the two-state drain machine.
   always_comb begin
      entries_d  = entries_q;
      head_d     = head_q;
      tail_d     = tail_q;
      state_d    = state_q;
      mem_req_d  = mem_req_q;
      mem_addr_d = mem_addr_q;
      mem_data_d = mem_data_q;

      if (alloc) begin
         entries_d[tail_q] = '{valid: 1'b1, addr: bus.wr_addr, data: bus.wr_data};
         tail_d            = tail_q + PTR_BITS'(1);
      end
      if (coal_wr) begin
         entries_d[coal_idx].data = bus.wr_data;
      end
      if (pop) begin
         entries_d[head_q].valid = 1'b0;
         head_d                  = head_q + PTR_BITS'(1);
      end
      count_d = count_q + (PTR_BITS+1)'(alloc) - (PTR_BITS+1)'(pop);

      case (state_q)
         DRAIN_IDLE: begin
            if (count_q != '0) begin
               state_d    = DRAIN_REQ;
               mem_req_d  = 1'b1;
               mem_addr_d = entries_q[head_q].addr;
               // A store merging into head on this very edge must reach memory.
               mem_data_d = (coal_wr && (coal_idx == head_q)) ? bus.wr_data
                                                              : entries_q[head_q].data;
            end
         end
         DRAIN_REQ: begin
            if (bus.mem_ack) begin
               state_d   = DRAIN_IDLE;
               mem_req_d = 1'b0;
            end
         end
         default: state_d = DRAIN_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < DEPTH; i++) begin
            entries_q[i] <= '0;
         end
         head_q     <= '0;
         tail_q     <= '0;
         count_q    <= '0;
         state_q    <= DRAIN_IDLE;
         mem_req_q  <= 1'b0;
         mem_addr_q <= '0;
         mem_data_q <= '0;
      end else begin
         entries_q  <= entries_d;
         head_q     <= head_d;
         tail_q     <= tail_d;
         count_q    <= count_d;
         state_q    <= state_d;
         mem_req_q  <= mem_req_d;
         mem_addr_q <= mem_addr_d;
         mem_data_q <= mem_data_d;
      end
   end

   assign bus.mem_req  = mem_req_q;
   assign bus.mem_addr = mem_addr_q;
   assign bus.mem_data = mem_data_q;
   assign count        = count_q;
   assign empty        = (count_q == '0) && (state_q == DRAIN_IDLE);

endmodule

// File: tb/tb_write_buffer.sv
// Testbench for write_buffer: scoreboard of buffered stores checked against
// memory drains, lookups and occupancy. Also exercises WB_COALESCE_EN when defined.
module tb_write_buffer;
   import cache_pkg::*;

   localparam int DEPTH = 4;

   typedef struct {
      logic [ADDR_WIDTH-1:0] addr;
      logic [DATA_WIDTH-1:0] data;
   } sb_item_t;

   logic       clk;
   logic       reset;
   logic       empty;
   logic [2:0] count;

   sb_item_t sb_q[$];
   int       total;
   int       bad;

   write_buffer_if bus ();

   write_buffer #(.DEPTH(DEPTH)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus),
      .empty (empty),
      .count (count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Expected lookup result: youngest buffered store to the address.
   function automatic void model_lookup(input logic [ADDR_WIDTH-1:0] a,
                                        output logic hit, output logic [DATA_WIDTH-1:0] d);
      hit = 1'b0;
      d   = '0;
      foreach (sb_q[i]) begin
         if (sb_q[i].addr == a) begin
            hit = 1'b1;
            d   = sb_q[i].data;
         end
      end
   endfunction

   task automatic do_push(input logic [ADDR_WIDTH-1:0] a, input logic [DATA_WIDTH-1:0] d);
      logic exp_ready;
      exp_ready    = (sb_q.size() < DEPTH);
      bus.wr_valid = 1'b1;
      bus.wr_addr  = a;
      bus.wr_data  = d;
      #1;
      total++;
      if (bus.wr_ready !== exp_ready) begin
         bad++;
         $display("[TB] FAIL push_ready addr=%h got=%b exp=%b", a, bus.wr_ready, exp_ready);
      end
      @(posedge clk);
      if (exp_ready) sb_q.push_back('{addr: a, data: d});
      @(negedge clk);
      bus.wr_valid = 1'b0;
   endtask

   task automatic drain_one(input int delay);
      int       waited;
      sb_item_t exp;
      waited = 0;
      while (bus.mem_req !== 1'b1 && waited < 20) begin
         @(negedge clk);
         waited++;
      end
      total++;
      if (bus.mem_req !== 1'b1 || sb_q.size() == 0) begin
         bad++;
         $display("[TB] FAIL drain_req got=%b exp=1 queued=%0d", bus.mem_req, sb_q.size());
         return;
      end
      exp = sb_q[0];
      total++;
      if (bus.mem_addr !== exp.addr || bus.mem_data !== exp.data) begin
         bad++;
         $display("[TB] FAIL drain_data got=%h/%h exp=%h/%h",
                  bus.mem_addr, bus.mem_data, exp.addr, exp.data);
      end
      for (int i = 0; i < delay; i++) begin
         @(negedge clk);
         total++;
         if (bus.mem_req !== 1'b1 || bus.mem_addr !== exp.addr || bus.mem_data !== exp.data) begin
            bad++;
            $display("[TB] FAIL drain_hold got=%b %h/%h exp=1 %h/%h",
                     bus.mem_req, bus.mem_addr, bus.mem_data, exp.addr, exp.data);
         end
      end
      bus.mem_ack = 1'b1;
      @(negedge clk);
      bus.mem_ack = 1'b0;
      void'(sb_q.pop_front());
      total++;
      if (bus.mem_req !== 1'b0) begin
         bad++;
         $display("[TB] FAIL drain_release got=%b exp=0", bus.mem_req);
      end
   endtask

   task automatic apply_reset();
      @(negedge clk);
      #2 reset = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      sb_q.delete();
   endtask

   task automatic test_reset();
      bus.wr_valid = 1'b0;
      bus.wr_addr  = '0;
      bus.wr_data  = '0;
      bus.mem_ack  = 1'b0;
      bus.lk_addr  = 10'h3FF;
      reset        = 1'b1;
      #1 reset     = 1'b0;
      repeat (3) @(negedge clk);
      total++;
      if (empty !== 1'b1 || count !== 3'd0 || bus.mem_req !== 1'b0 || bus.wr_ready !== 1'b1 ||
          bus.mem_addr !== '0 || bus.mem_data !== '0 || bus.lk_hit !== 1'b0) begin
         bad++;
         $display("[TB] FAIL reset_hold got=e%b c%0d r%b w%b a%h d%h h%b exp=e1 c0 r0 w1 a0 d0 h0",
                  empty, count, bus.mem_req, bus.wr_ready, bus.mem_addr, bus.mem_data, bus.lk_hit);
      end
      reset = 1'b1;
      repeat (3) begin
         @(negedge clk);
         total++;
         if (empty !== 1'b1 || count !== 3'd0 || bus.mem_req !== 1'b0 || bus.wr_ready !== 1'b1) begin
            bad++;
            $display("[TB] FAIL idle got=e%b c%0d r%b w%b exp=e1 c0 r0 w1",
                     empty, count, bus.mem_req, bus.wr_ready);
         end
      end
   endtask

   task automatic test_single_store();
      do_push(10'h045, 32'hDEADBEEF);
      total++;
      if (bus.mem_req !== 1'b0 || count !== 3'd1 || empty !== 1'b0) begin
         bad++;
         $display("[TB] FAIL single_pre got=r%b c%0d e%b exp=r0 c1 e0", bus.mem_req, count, empty);
      end
      @(negedge clk);
      total++;
      if (bus.mem_req !== 1'b1) begin
         bad++;
         $display("[TB] FAIL single_req_latency got=%b exp=1", bus.mem_req);
      end
      drain_one(1);
      total++;
      if (empty !== 1'b1 || count !== 3'd0) begin
         bad++;
         $display("[TB] FAIL single_empty got=e%b c%0d exp=e1 c0", empty, count);
      end
   endtask

   task automatic test_fill_wrap();
      apply_reset();
      for (int i = 1; i <= 4; i++) begin
         do_push(ADDR_WIDTH'(i), DATA_WIDTH'(i * 17));
      end
      #1;
      total++;
      if (count !== 3'd4 || bus.wr_ready !== 1'b0) begin
         bad++;
         $display("[TB] FAIL fill_full got=c%0d w%b exp=c4 w0", count, bus.wr_ready);
      end
      do_push(10'h005, 32'h55);
      total++;
      if (count !== 3'(sb_q.size())) begin
         bad++;
         $display("[TB] FAIL fill_reject got=%0d exp=%0d", count, sb_q.size());
      end
      // Ack and a store on the same edge while full: no bypass.
      total++;
      if (bus.mem_req !== 1'b1 || bus.mem_addr !== sb_q[0].addr) begin
         bad++;
         $display("[TB] FAIL fill_head got=r%b a%h exp=r1 a%h", bus.mem_req, bus.mem_addr, sb_q[0].addr);
      end
      bus.mem_ack  = 1'b1;
      bus.wr_valid = 1'b1;
      #1;
      total++;
      if (bus.wr_ready !== 1'b0) begin
         bad++;
         $display("[TB] FAIL full_no_bypass got=%b exp=0", bus.wr_ready);
      end
      @(negedge clk);
      bus.mem_ack  = 1'b0;
      bus.wr_valid = 1'b0;
      void'(sb_q.pop_front());
      total++;
      if (count !== 3'(sb_q.size())) begin
         bad++;
         $display("[TB] FAIL full_pop_count got=%0d exp=%0d", count, sb_q.size());
      end
      repeat (3) drain_one(0);
      do_push(10'h006, 32'h66);
      do_push(10'h007, 32'h77);
      repeat (2) drain_one(0);
      total++;
      if (empty !== 1'b1 || count !== 3'd0) begin
         bad++;
         $display("[TB] FAIL wrap_empty got=e%b c%0d exp=e1 c0", empty, count);
      end
   endtask

   task automatic test_forwarding();
      logic                  exp_hit;
      logic [DATA_WIDTH-1:0] exp_data;
      do_push(10'h010, 32'hAAAA);
      repeat (2) @(negedge clk);
      do_push(10'h012, 32'h1212);
      do_push(10'h010, 32'hBBBB);
      bus.lk_addr = 10'h010;
      #1;
      model_lookup(10'h010, exp_hit, exp_data);
      total++;
      if (bus.lk_hit !== exp_hit || bus.lk_data !== exp_data) begin
         bad++;
         $display("[TB] FAIL fwd_youngest got=%b/%h exp=%b/%h", bus.lk_hit, bus.lk_data, exp_hit, exp_data);
      end
      bus.lk_addr = 10'h011;
      #1;
      model_lookup(10'h011, exp_hit, exp_data);
      total++;
      if (bus.lk_hit !== exp_hit || bus.lk_data !== exp_data) begin
         bad++;
         $display("[TB] FAIL fwd_miss got=%b/%h exp=%b/%h", bus.lk_hit, bus.lk_data, exp_hit, exp_data);
      end
      bus.lk_addr  = 10'h020;
      bus.wr_valid = 1'b1;
      bus.wr_addr  = 10'h020;
      bus.wr_data  = 32'h2020;
      #1;
      model_lookup(10'h020, exp_hit, exp_data);
      total++;
      if (bus.lk_hit !== exp_hit || bus.lk_data !== exp_data) begin
         bad++;
         $display("[TB] FAIL fwd_same_cycle got=%b/%h exp=%b/%h", bus.lk_hit, bus.lk_data, exp_hit, exp_data);
      end
      @(posedge clk);
      sb_q.push_back('{addr: 10'h020, data: 32'h2020});
      @(negedge clk);
      bus.wr_valid = 1'b0;
      #1;
      model_lookup(10'h020, exp_hit, exp_data);
      total++;
      if (bus.lk_hit !== exp_hit || bus.lk_data !== exp_data) begin
         bad++;
         $display("[TB] FAIL fwd_next_cycle got=%b/%h exp=%b/%h", bus.lk_hit, bus.lk_data, exp_hit, exp_data);
      end
      bus.lk_addr = 10'h3FF;
      repeat (4) drain_one(0);
   endtask

   task automatic test_back_to_back();
      logic                  exp_hit;
      logic [DATA_WIDTH-1:0] exp_data;
      do_push(10'h030, 32'h3030);
      do_push(10'h031, 32'h3131);
      total++;
      if (bus.mem_req !== 1'b1 || count !== 3'd2) begin
         bad++;
         $display("[TB] FAIL b2b_setup got=r%b c%0d exp=r1 c2", bus.mem_req, count);
      end
      bus.mem_ack  = 1'b1;
      bus.wr_valid = 1'b1;
      bus.wr_addr  = 10'h032;
      bus.wr_data  = 32'h3232;
      @(posedge clk);
      void'(sb_q.pop_front());
      sb_q.push_back('{addr: 10'h032, data: 32'h3232});
      @(negedge clk);
      bus.mem_ack  = 1'b0;
      bus.wr_valid = 1'b0;
      total++;
      if (count !== 3'd2) begin
         bad++;
         $display("[TB] FAIL b2b_count got=%0d exp=2", count);
      end
      for (int i = 0; i < 2; i++) begin
         bus.lk_addr = (i == 0) ? 10'h030 : 10'h032;
         #1;
         model_lookup(bus.lk_addr, exp_hit, exp_data);
         total++;
         if (bus.lk_hit !== exp_hit || bus.lk_data !== exp_data) begin
            bad++;
            $display("[TB] FAIL b2b_lookup addr=%h got=%b/%h exp=%b/%h",
                     bus.lk_addr, bus.lk_hit, bus.lk_data, exp_hit, exp_data);
         end
      end
      bus.lk_addr = 10'h3FF;
      repeat (2) drain_one(0);
   endtask

   task automatic test_reset_mid_drain();
      for (int i = 1; i <= 3; i++) begin
         do_push(ADDR_WIDTH'(10'h040 + i), DATA_WIDTH'(32'h4000 + i));
      end
      total++;
      if (bus.mem_req !== 1'b1 || count !== 3'd3) begin
         bad++;
         $display("[TB] FAIL mid_setup got=r%b c%0d exp=r1 c3", bus.mem_req, count);
      end
      bus.lk_addr = 10'h041;
      #2 reset = 1'b0;
      #1;
      total++;
      if (bus.mem_req !== 1'b0 || count !== 3'd0 || empty !== 1'b1 || bus.lk_hit !== 1'b0) begin
         bad++;
         $display("[TB] FAIL mid_reset got=r%b c%0d e%b h%b exp=r0 c0 e1 h0",
                  bus.mem_req, count, empty, bus.lk_hit);
      end
      @(negedge clk);
      reset = 1'b1;
      sb_q.delete();
      bus.lk_addr = 10'h3FF;
      @(negedge clk);
      total++;
      if (bus.mem_req !== 1'b0 || empty !== 1'b1) begin
         bad++;
         $display("[TB] FAIL mid_after got=r%b e%b exp=r0 e1", bus.mem_req, empty);
      end
`ifdef WB_COALESCE_EN
      for (int i = 1; i <= 4; i++) begin
         do_push(ADDR_WIDTH'(i), DATA_WIDTH'(i * 17));
      end
      bus.wr_valid = 1'b1;
      bus.wr_addr  = 10'h003;
      bus.wr_data  = 32'h99;
      #1;
      total++;
      if (bus.wr_ready !== 1'b1) begin
         bad++;
         $display("[TB] FAIL coal_ready got=%b exp=1", bus.wr_ready);
      end
      @(posedge clk);
      sb_q[2].data = 32'h99;
      @(negedge clk);
      bus.wr_valid = 1'b0;
      total++;
      if (count !== 3'd4) begin
         bad++;
         $display("[TB] FAIL coal_count got=%0d exp=4", count);
      end
      repeat (4) drain_one(0);
`endif
   endtask

   initial begin
      total = 0;
      bad   = 0;
      test_reset();
      test_single_store();
      test_fill_wrap();
      test_forwarding();
      test_back_to_back();
      test_reset_mid_drain();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog got=timeout exp=finish");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule

// File: doc/write_buffer.md
Name: write_buffer

Overview:
Write-through store buffer between the L1 direct-mapped cache controller and main memory. It queues cache write-through stores (addr, data) in a small circular FIFO and drains them to memory through a req/ack handshake, so the controller never waits on memory for a write. It also provides a combinational lookup port so that read-miss fills see buffered data that has not yet drained (read-after-write forwarding).

Parameters:
DATA_WIDTH, 32, data word width
ADDR_WIDTH, 10, main-memory block address width (log2 of MM block count 1024)
DEPTH, 4, FIFO entries; power of two, >=2
PTR_BITS, $clog2(DEPTH), pointer width (derived)

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-low reset
wr_valid  in  1  controller presents a store
wr_ready  out  1  buffer can accept the store this cycle
wr_addr  in  ADDR_WIDTH  store address {tag,index}
wr_data  in  DATA_WIDTH  store data
lk_addr  in  ADDR_WIDTH  lookup address for a read-miss fill
lk_hit  out  1  a buffered entry matches lk_addr
lk_data  out  DATA_WIDTH  data of the youngest matching entry
mem_req  out  1  write request to main memory
mem_ack  in  1  memory accepted the write (single-cycle pulse)
mem_addr  out  ADDR_WIDTH  write address
mem_data  out  DATA_WIDTH  write data
empty  out  1  no entries held and no write in flight
count  out  PTR_BITS+1  entries occupied, 0..DEPTH

Behaviour:
- Reset (reset=0, async): head=tail=0, count=0, all entry valid bits cleared, FSM=DRAIN_IDLE. Outputs: wr_ready=1, mem_req=0, mem_addr=0, mem_data=0, lk_hit=0, empty=1. Reset mid-drain abandons the write in flight; buffered stores are lost by design.
- Push: a store is accepted on a rising edge with wr_valid && wr_ready. It is written at tail, and tail increments modulo DEPTH (wraps DEPTH-1 -> 0). wr_ready = (count != DEPTH). When full there is no same-cycle bypass, even if mem_ack pops that cycle.
- Drain FSM, registered:
  - DRAIN_IDLE: if count>0, latch entry[head] into mem_addr/mem_data, set mem_req=1, go to DRAIN_REQ.
  - DRAIN_REQ: hold mem_req, mem_addr and mem_data stable until mem_ack=1. On ack: pop head (head+1 mod DEPTH, clear valid), mem_req=0, go to DRAIN_IDLE.
  - Consequence: peak drain rate is one store per 2 cycles. The first mem_req appears 1 cycle after the push edge.
  - mem_ack while in DRAIN_IDLE is ignored.
- Simultaneous push and pop in one cycle: count unchanged, both pointers advance.
- count: +1 on push only, -1 on pop only. It never exceeds DEPTH or goes below 0. empty = (count==0) && (state==DRAIN_IDLE).
- Lookup (combinational):
  - Compares lk_addr against all valid entries, including the head in flight.
  - lk_hit=1 if any entry matches. lk_data is the youngest match by age from head, not by index. lk_data=0 when there is no hit.
  - A store being pushed in the same cycle is not visible until the next cycle.
- Ordering: stores to memory leave in strict push order, except under the optional feature below.

Optional Feature:
Macro WB_COALESCE_EN.
- Defined:
  - An incoming store whose wr_addr matches a valid entry overwrites that entry's data in place. Tail and count are unchanged.
  - The entry at head is excluded while state==DRAIN_REQ, since its data is already presented to memory.
  - A coalescing store is accepted even when full: wr_ready = !full || coalesce_match.
  - If several entries match, the youngest is updated.
- Undefined: every accepted store allocates a new entry. wr_ready = !full.

Decomposition:
- Shared package cache_pkg holds:
  - DATA_WIDTH, ADDR_WIDTH (MM_BLOCK_COUNT_BITS), L1 index/tag widths as localparams.
  - typedef enum logic [0:0] {DRAIN_IDLE, DRAIN_REQ} wb_drain_state_t.
  - typedef struct packed {logic valid; logic [ADDR_WIDTH-1:0] addr; logic [DATA_WIDTH-1:0] data;} wb_entry_t.
- One sub-module, wb_match, is natural: a combinational age-ordered CAM search returning hit, youngest index and data. It is used by both the lookup port and the coalesce logic.

Test Plan:
1. Reset then idle: hold reset=0 for 3 cycles, release, no stimulus. Required: empty=1, count=0, mem_req=0, wr_ready=1 throughout.
2. Single store: push addr=0x045, data=0xDEADBEEF, with mem_ack returned 2 cycles after mem_req rises. Required: mem_req rises 1 cycle after the push and holds addr/data stable until the ack; empty=1 one cycle after the ack.
3. Fill and wrap: mem_ack held 0, push 4 stores (0x001..0x004, data 0x11..0x44). Required: count=4, wr_ready=0. A 5th wr_valid is not accepted. Then pulse ack 4 times: memory sees 0x001..0x004 in order. Push 2 more: entries land at slots 0,1 (wrap).
4. Forwarding: buffer 0x010=0xAAAA then 0x010=0xBBBB (feature off), lk_addr=0x010. Required: lk_hit=1, lk_data=0xBBBB. lk_addr=0x011 gives lk_hit=0, lk_data=0.
5. Simultaneous push and pop: count=2, state DRAIN_REQ, mem_ack=1 with a push on the same edge. Required: count stays 2, head and tail both advance.
6. Reset mid-drain: mem_req=1 with 3 entries, assert reset asynchronously between edges. Required: mem_req=0 and count=0 immediately. With WB_COALESCE_EN, a full buffer still accepts a store to a non-head matching address and count stays 4.
